// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared op-code constants, FSM state encoding and op decode helpers
// for the EX-stage multiply/divide unit.
package ex_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU};
  endfunction

  // rs1 is sign-extended for MULH/MULHSU, rs2 only for MULH
  function automatic logic mul_s1(input logic [2:0] op);
    return op inside {MDU_MULH, MDU_MULHSU};
  endfunction

  function automatic logic mul_s2(input logic [2:0] op);
    return op == MDU_MULH;
  endfunction

  function automatic logic mul_hi(input logic [2:0] op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
  endfunction

  function automatic logic div_signed(input logic [2:0] op);
    return op inside {MDU_DIV, MDU_REM};
  endfunction

  function automatic logic div_rem(input logic [2:0] op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: radix-2 restoring divider on unsigned magnitudes, one quotient
// bit per cycle, XLEN iterations. last_o flags the final iteration cycle and
// quot_o/rem_o carry that iteration's result so the caller can capture it on
// the same edge.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            annul_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            last_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] quot_n, rem_n;

  // one restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_sh = {rem_q, quot_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    rem_n  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quot_n = {quot_q[XLEN-2:0], ~diff[XLEN]};
  end

  assign last_o = busy_q & (cnt_q == LAST);
  assign quot_o = quot_n;
  assign rem_o  = rem_n;

  // iteration control: load on start, step while busy, drop on annul
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    if (annul_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quot_d = dividend_i;
      rem_d  = '0;
      dsr_d  = divisor_i;
    end else if (busy_q) begin
      quot_d = quot_n;
      rem_d  = rem_n;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  // divider state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle RV32M/RV64M multiply/divide unit next to the EX ALU.
// Holds the pipeline via stallreq_o until a registered result is returned
// with its destination tag. Define MDU_DIV_EN to build the iterative divider;
// without it, divide ops complete in one cycle with a zero result.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      wd_i,
  input  logic            annul_i,
  output logic            stallreq_o,
  output logic            done_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES - 1);

  mdu_state_e      state_q, state_d;
  logic [4:0]      wd_q, wd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            done_q, done_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            hi_q, hi_d;
  logic            accept;

  logic [2*XLEN-1:0] ma, mb, mp;
  logic [2*XLEN-1:0] prod_q [MUL_STAGES];

  assign accept = (state_q == S_IDLE) & start_i & ~annul_i;

  // operands extended to 2*XLEN so the wrapped product is exact for every sign mix
  always_comb begin
    ma = {{XLEN{mul_s1(op_i) & reg1_i[XLEN-1]}}, reg1_i};
    mb = {{XLEN{mul_s2(op_i) & reg2_i[XLEN-1]}}, reg2_i};
    mp = ma * mb;
  end

  // product retiming chain; stage MUL_STAGES-1 is valid in the last MUL cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < MUL_STAGES; k++) prod_q[k] <= '0;
    end else begin
      if (accept) prod_q[0] <= mp;
      for (int k = 1; k < MUL_STAGES; k++) prod_q[k] <= prod_q[k-1];
    end
  end

`ifdef MDU_DIV_EN
  logic            qneg_q, qneg_d, rneg_q, rneg_d, rsel_q, rsel_d;
  logic            div_go, div_last, sdiv;
  logic [XLEN-1:0] mag1, mag2, div_quot, div_remw, div_res;

  // magnitudes for the unsigned core, and sign fix of its result
  always_comb begin
    sdiv    = div_signed(op_i);
    mag1    = (sdiv & reg1_i[XLEN-1]) ? -reg1_i : reg1_i;
    mag2    = (sdiv & reg2_i[XLEN-1]) ? -reg2_i : reg2_i;
    div_res = rsel_q ? (rneg_q ? -div_remw : div_remw)
                     : (qneg_q ? -div_quot : div_quot);
  end

  mdu_div_core #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_go),
    .annul_i    (annul_i),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .last_o     (div_last),
    .quot_o     (div_quot),
    .rem_o      (div_remw)
  );

  // sign/select flags captured at start for the final fix-up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      rsel_q <= rsel_d;
    end
  end
`endif

  // FSM next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
`ifdef MDU_DIV_EN
    div_go  = 1'b0;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    rsel_d  = rsel_q;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        wd_d  = wd_i;
        cnt_d = '0;
        hi_d  = mul_hi(op_i);
        if (is_mul(op_i)) begin
          state_d = S_MUL;
        end else begin
`ifdef MDU_DIV_EN
          qneg_d = sdiv & (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
          rneg_d = sdiv & reg1_i[XLEN-1];
          rsel_d = div_rem(op_i);
          if (reg2_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            wdata_d = div_rem(op_i) ? reg1_i : '1;
          end else if (sdiv && reg1_i == {1'b1, {(XLEN-1){1'b0}}} && reg2_i == '1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            wdata_d = div_rem(op_i) ? '0 : reg1_i;
          end else begin
            state_d = S_DIV;
            div_go  = 1'b1;
          end
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          wdata_d = '0;
`endif
        end
      end
      S_MUL: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          wdata_d = hi_q ? prod_q[MUL_STAGES-1][2*XLEN-1:XLEN]
                         : prod_q[MUL_STAGES-1][XLEN-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
`ifdef MDU_DIV_EN
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (div_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          wdata_d = div_res;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
    end
  end

  // stall drops in the annul cycle so the flushed pipeline moves immediately
  assign stallreq_o = accept | (((state_q == S_MUL) | (state_q == S_DIV)) & ~annul_i);
  assign done_o     = done_q & ~annul_i;
  assign wreg_o     = done_o;
  assign wdata_o    = wdata_q;
  assign wd_o       = wd_q;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed vector table plus hand-written flush/reset sequences for ex_mdu
// (XLEN=32, MUL_STAGES=2). Expectations follow the MDU_DIV_EN build setting.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] reg1_i = '0;
  logic [31:0] reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        annul_i = 1'b0;
  logic        stallreq_o, done_o, wreg_o;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;

`ifdef MDU_DIV_EN
  localparam bit DIVON = 1'b1;
`else
  localparam bit DIVON = 1'b0;
`endif

  ex_mdu #(.XLEN(32), .MUL_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .annul_i    (annul_i),
    .stallreq_o (stallreq_o),
    .done_o     (done_o),
    .wdata_o    (wdata_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wd;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // divide vectors collapse to a 1-cycle zero result when the divider is not built
  task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] wd, input logic [31:0] exp, input int lat,
                     input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.wd = wd; v.exp = exp; v.lat = lat; v.name = name;
    if (op[2] && !DIVON) begin
      v.exp = '0;
      v.lat = 1;
    end
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd);
    @(negedge clk);
    op_i = op; reg1_i = a; reg2_i = b; wd_i = wd; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // issue one op at cycle 0, watch stall/done each cycle up to lat+3
  task automatic run_op(input vec_t v);
    int          got;
    bit          stall_bad;
    logic        exp_s;
    logic [31:0] dat;
    logic [4:0]  wdg;
    logic        wrg;
    got = -1; stall_bad = 1'b0; dat = '0; wdg = '0; wrg = 1'b0;
    @(negedge clk);
    op_i = v.op; reg1_i = v.a; reg2_i = v.b; wd_i = v.wd; start_i = 1'b1;
    #1;
    if (stallreq_o !== 1'b1) stall_bad = 1'b1;
    for (int k = 1; k <= v.lat + 3; k++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      #1;
      exp_s = (k < v.lat);
      if (stallreq_o !== exp_s) stall_bad = 1'b1;
      if (done_o === 1'b1) begin
        if (got < 0) begin
          got = k; dat = wdata_o; wdg = wd_o; wrg = wreg_o;
        end else begin
          got = -2;
        end
      end
    end
    chk({v.name, ".lat"},   32'(got), 32'(v.lat));
    chk({v.name, ".data"},  dat, v.exp);
    chk({v.name, ".wd"},    {27'd0, wdg}, {27'd0, v.wd});
    chk({v.name, ".wreg"},  {31'd0, wrg}, 32'd1);
    chk({v.name, ".stall"}, {31'd0, stall_bad}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    bit   seen;
    bit   bad;
    logic [2:0] long_op;
    int   a_cyc, r_cyc;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.done",  {31'd0, done_o},     32'd0);
    chk("rst.wreg",  {31'd0, wreg_o},     32'd0);
    chk("rst.wdata", wdata_o,             32'd0);
    chk("rst.wd",    {27'd0, wd_o},       32'd0);
    chk("rst.stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    add(3'd0, 32'd3,        32'd5,        5'd1,  32'd15,         3,  "mul_3x5");
    add(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000001,   3,  "mul_m1m1");
    add(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000,   3,  "mulh_m1m1");
    add(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE,   3,  "mulhu_max");
    add(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF,   3,  "mulhsu_m1");
    add(3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000,   3,  "mulh_min");
    add(3'd0, 32'h12345678, 32'h00000010, 5'd7,  32'h23456780,   3,  "mul_shift");
    add(3'd4, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD,   33, "div_m7_2");
    add(3'd6, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF,   33, "rem_m7_2");
    add(3'd5, 32'd100,      32'd0,        5'd10, 32'hFFFFFFFF,   1,  "divu_by0");
    add(3'd7, 32'd100,      32'd0,        5'd11, 32'd100,        1,  "remu_by0");
    add(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000,   1,  "div_ovf");
    add(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000,   1,  "rem_ovf");
    add(3'd5, 32'd100,      32'd7,        5'd14, 32'd14,         33, "divu_100_7");
    add(3'd7, 32'd100,      32'd7,        5'd15, 32'd2,          33, "remu_100_7");
    add(3'd4, 32'd100,      32'hFFFFFFF9, 5'd16, 32'hFFFFFFF2,   33, "div_100_m7");
    add(3'd6, 32'd100,      32'hFFFFFFF9, 5'd17, 32'd2,          33, "rem_100_m7");
    add(3'd4, 32'h80000000, 32'd2,        5'd18, 32'hC0000000,   33, "div_min_2");
    add(3'd7, 32'hFFFFFFFF, 32'h00000010, 5'd19, 32'h0000000F,   33, "remu_max_16");
    add(3'd4, 32'd5,        32'd0,        5'd20, 32'hFFFFFFFF,   1,  "div_by0");
    add(3'd6, 32'hFFFFFFFB, 32'd0,        5'd21, 32'hFFFFFFFB,   1,  "rem_by0");

    foreach (vecs[i]) run_op(vecs[i]);

    long_op = DIVON ? 3'd5 : 3'd0;
    a_cyc   = DIVON ? 10 : 2;
    r_cyc   = DIVON ? 5 : 2;

    // flush in the middle of a long op
    start_op(long_op, 32'd100, 32'd7, 5'd9);
    repeat (a_cyc - 1) step();
    annul_i = 1'b1;
    #1;
    chk("annul.stall_drop", {31'd0, stallreq_o}, 32'd0);
    step();
    annul_i = 1'b0;
    #1;
    chk("annul.idle", {31'd0, stallreq_o}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done_o !== 1'b0) seen = 1'b1;
      step();
    end
    chk("annul.no_done", {31'd0, seen}, 32'd0);
    v.op = 3'd0; v.a = 32'd3; v.b = 32'd5; v.wd = 5'd22; v.exp = 32'd15; v.lat = 3;
    v.name = "annul.mul";
    run_op(v);

    // flush together with start in IDLE: start ignored
    @(negedge clk);
    op_i = 3'd0; reg1_i = 32'd3; reg2_i = 32'd5; wd_i = 5'd23; start_i = 1'b1; annul_i = 1'b1;
    #1;
    chk("annul_start.stall", {31'd0, stallreq_o}, 32'd0);
    step();
    start_i = 1'b0; annul_i = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (done_o !== 1'b0 || stallreq_o !== 1'b0) bad = 1'b1;
      step();
    end
    chk("annul_start.ignored", {31'd0, bad}, 32'd0);

    // flush in DONE masks the result pulse
    start_op(3'd0, 32'd3, 32'd5, 5'd24);
    step();
    step();
    annul_i = 1'b1;
    #1;
    chk("annul_done.done", {31'd0, done_o}, 32'd0);
    chk("annul_done.wreg", {31'd0, wreg_o}, 32'd0);
    step();
    annul_i = 1'b0;

    // asynchronous reset mid-operation
    start_op(long_op, 32'd100, 32'd7, 5'd25);
    repeat (r_cyc - 1) step();
    rst = 1'b0;
    #1;
    chk("rst_mid.done",  {31'd0, done_o},     32'd0);
    chk("rst_mid.wreg",  {31'd0, wreg_o},     32'd0);
    chk("rst_mid.wdata", wdata_o,             32'd0);
    chk("rst_mid.wd",    {27'd0, wd_o},       32'd0);
    chk("rst_mid.stall", {31'd0, stallreq_o}, 32'd0);
    step();
    @(negedge clk);
    rst = 1'b1;
    v.op = 3'd0; v.a = 32'd3; v.b = 32'd5; v.wd = 5'd26; v.exp = 32'd15; v.lat = 3;
    v.name = "rst_mid.mul";
    run_op(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
